sram_bridge: RTL

- Bus slave that sits directly downstream of the bexkat CPU bus master.
- Accepts 32-bit read/write requests qualified by byteenable and holds waitrequest high while they are in progress.
- Executes each request as one or two 16-bit accesses on an external asynchronous SRAM, with a programmable strobe width.
- Returns sign-agnostic, lane-aligned readdata; the CPU performs its own lane selection and sign extension.

---
 rtl/sram_bridge_pkg.sv | 28 ++
 rtl/sram_phase_timer.sv | 43 ++++
 rtl/sram_bridge.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_bridge_pkg.sv
// Shared types and constants for the CPU-bus to asynchronous-SRAM bridge.
package sram_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_e;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    localparam int unsigned WAIT_MIN = 1;
    localparam int unsigned WAIT_MAX = 15;
    localparam int unsigned CNT_W    = 4;

    // Counter preset for a strobe of the requested length, clamped to the legal range.
    function automatic logic [CNT_W-1:0] wait_load(input int unsigned cycles);
        int unsigned c;
        c = cycles;
        if (c < WAIT_MIN) c = WAIT_MIN;
        if (c > WAIT_MAX) c = WAIT_MAX;
        return CNT_W'(c - 1);
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Strobe-width timer: preset during SETUP, counts down through STROBE, flags the final cycle.
module sram_phase_timer
    import sram_bridge_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic en_i,
    output logic last_strobe_o
);

    localparam logic [CNT_W-1:0] LOAD_VAL = wait_load(WAIT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;

    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (load_i) begin
            cnt_d  = LOAD_VAL;
            last_d = (LOAD_VAL == '0);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d  = cnt_q - CNT_W'(1);
            last_d = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign last_strobe_o = last_q;

endmodule

// File: rtl/sram_bridge.sv
// Bexkat bus slave executing 32-bit requests as one or two 16-bit async-SRAM accesses.
module sram_bridge
    import sram_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

    localparam int unsigned WA_W = ADDR_W - 1;

    state_e            state_q, state_d;
    logic              half_q, half_d;
    logic [WA_W-1:0]   waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              wr_q, wr_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]       dq_out_q, dq_out_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              lb_n_q, lb_n_d;
    logic              ub_n_q, ub_n_d;

    logic              req_c;
    logic              last_strobe;
    logic [15:0]       mask_lo_c, mask_hi_c;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{address[31:ADDR_W+1], address[1:0]};

    assign req_c       = read | write;
    assign waitrequest = req_c && (state_q != DONE);

    assign mask_lo_c = {{8{be_q[1]}}, {8{be_q[0]}}};
    assign mask_hi_c = {{8{be_q[3]}}, {8{be_q[2]}}};

    sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk_i         (clk),
        .reset_i       (reset),
        .load_i        (state_q == SETUP),
        .en_i          (state_q == STROBE),
        .last_strobe_o (last_strobe)
    );

    // Next-state, request latching and read capture.
    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (req_c) begin
                    waddr_d = address[ADDR_W:2];
                    wdata_d = writedata;
                    be_d    = byteenable;
                    wr_d    = write;
                    if (byteenable[1:0] != 2'b00) begin
                        half_d  = HALF_LO;
                        state_d = SETUP;
                    end else if (byteenable[3:2] != 2'b00) begin
                        half_d  = HALF_HI;
                        state_d = SETUP;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SETUP: state_d = STROBE;
            STROBE: begin
                if (last_strobe) begin
                    state_d = HOLD;
                    if (!wr_q) begin
                        // The first half captured in a request clears the other half's lanes.
                        if (half_q == HALF_LO) begin
                            rdata_d = {16'h0000, sram_dq_in & mask_lo_c};
                        end else begin
                            rdata_d = {sram_dq_in & mask_hi_c,
                                       (be_q[1:0] != 2'b00) ? rdata_q[15:0] : 16'h0000};
                        end
                    end
                end
            end
            HOLD: begin
                if ((half_q == HALF_LO) && (be_q[3:2] != 2'b00)) begin
                    half_d  = HALF_HI;
                    state_d = SETUP;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SRAM pin values for the upcoming state, so every pin comes straight from a flop.
    always_comb begin
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;

        if ((state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD)) begin
            ce_n_d  = 1'b0;
            lb_n_d  = ~((half_d == HALF_HI) ? be_d[2] : be_d[0]);
            ub_n_d  = ~((half_d == HALF_HI) ? be_d[3] : be_d[1]);
            dq_oe_d = wr_d;
            if (state_d == SETUP) begin
                sram_addr_d = {waddr_d, half_d};
                if (wr_d) begin
                    dq_out_d = (half_d == HALF_HI) ? wdata_d[31:16] : wdata_d[15:0];
                end
            end
            if (state_d == STROBE) begin
                oe_n_d = wr_d;
                we_n_d = ~wr_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            half_q      <= HALF_LO;
            waddr_q     <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            wr_q        <= 1'b0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            wr_q        <= wr_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            lb_n_q      <= lb_n_d;
            ub_n_q      <= ub_n_d;
        end
    end

    assign readdata    = rdata_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_lb_n   = lb_n_q;
    assign sram_ub_n   = ub_n_q;

endmodule
